// File: rtl/dat_mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional build macro: DAT_MEM_ARB_RR_EN (round-robin on contention).
package dat_mem_arb_pkg;

  localparam int ARB_AW_DEF       = 8;
  localparam int ARB_DW_DEF       = 8;
  localparam int ARB_LOCK_MAX_DEF = 16;

  // Memory owner for the current cycle; CPU/HOST each mean one access.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_HOST = 2'd2
  } arb_owner_e;

  // The requester that did not get the last grant.
  function automatic arb_owner_e arb_other(input arb_owner_e last);
    return (last == ARB_CPU) ? ARB_HOST : ARB_CPU;
  endfunction

endpackage

// File: rtl/dat_mem_arbiter_lock_ctr.sv
// Saturating counter of consecutive host grants. at_max is high in the
// grant cycle that brings the run to LOCK_MAX, so the arbiter may hand
// the memory to a waiting core at the end of that cycle.
module arb_lock_ctr #(
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, increment saturates at LOCK_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(LOCK_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q >= CW'(LOCK_MAX - 1));

endmodule

// File: rtl/dat_mem_arbiter.sv
// Single-port data memory arbiter between the core load/store path and a
// host port. One access per cycle, registered read return per requester.
// Optional build macro: DAT_MEM_ARB_RR_EN -- alternate winners on
// contention instead of fixed core priority.
//
// Handshake: a requester raises req with we/addr/wdat and holds them stable
// until it sees its gnt. The access happens in the gnt cycle; a req still
// high during that cycle is taken as the next transaction. Reads return
// rvalid (one cycle) with rdat in the cycle after gnt; writes return nothing.
module dat_mem_arbiter
  import dat_mem_arb_pkg::*;
#(
  parameter int AW       = ARB_AW_DEF,
  parameter int DW       = ARB_DW_DEF,
  parameter int LOCK_MAX = ARB_LOCK_MAX_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdat,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdat,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdat,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic [1:0]    dbg_owner
);

  arb_owner_e    owner_q, owner_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] cpu_rdat_q, cpu_rdat_d;
  logic [DW-1:0] host_rdat_q, host_rdat_d;
  logic          lock_at_max;
  logic          lock_hold;

`ifdef DAT_MEM_ARB_RR_EN
  arb_owner_e    last_q, last_d;
`endif

  arb_lock_ctr #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_ctr (
    .clk    (Clk),
    .rst    (Reset),
    .clr    (owner_q != ARB_HOST),
    .inc    (owner_q == ARB_HOST),
    .at_max (lock_at_max)
  );

  // Host keeps the memory while it asks for a locked run that is not used up.
  assign lock_hold = (owner_q == ARB_HOST) && host_req && host_lock && !lock_at_max;

  // Owner state register (plus round-robin pointer when enabled).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      owner_q <= ARB_IDLE;
`ifdef DAT_MEM_ARB_RR_EN
      last_q  <= ARB_HOST;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef DAT_MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next owner: lock first, then contention rule, then single requester.
  always_comb begin
    owner_d = ARB_IDLE;
    if (lock_hold) begin
      owner_d = ARB_HOST;
    end else if (cpu_req && host_req) begin
`ifdef DAT_MEM_ARB_RR_EN
      owner_d = arb_other(last_q);
`else
      owner_d = ARB_CPU;
`endif
    end else if (cpu_req) begin
      owner_d = ARB_CPU;
    end else if (host_req) begin
      owner_d = ARB_HOST;
    end
`ifdef DAT_MEM_ARB_RR_EN
    last_d = (owner_d != ARB_IDLE) ? owner_d : last_q;
`endif
  end

  // Grants and memory drive from the current owner; IDLE drives zeros.
  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_in    = '0;
    case (owner_q)
      ARB_CPU: begin
        cpu_gnt   = 1'b1;
        mem_wr_en = cpu_we;
        mem_addr  = cpu_addr;
        mem_in    = cpu_wdat;
      end
      ARB_HOST: begin
        host_gnt  = 1'b1;
        mem_wr_en = host_we;
        mem_addr  = host_addr;
        mem_in    = host_wdat;
      end
      default: begin
        cpu_gnt   = 1'b0;
        host_gnt  = 1'b0;
      end
    endcase
  end

  // Read return: capture memory data at the end of a read grant.
  always_comb begin
    cpu_rvalid_d  = cpu_gnt && !cpu_we;
    host_rvalid_d = host_gnt && !host_we;
    cpu_rdat_d    = cpu_rvalid_d ? mem_out : cpu_rdat_q;
    host_rdat_d   = host_rvalid_d ? mem_out : host_rdat_q;
  end

  // Read return registers; rdat holds between reads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdat_q    <= '0;
      host_rdat_q   <= '0;
    end else begin
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdat_q    <= cpu_rdat_d;
      host_rdat_q   <= host_rdat_d;
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdat    = cpu_rdat_q;
  assign host_rdat   = host_rdat_q;
  assign cpu_stall   = cpu_req && !cpu_gnt;
  assign busy        = cpu_gnt || host_gnt || cpu_rvalid_q || host_rvalid_q;
  assign dbg_owner   = owner_q;

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Bench for dat_mem_arbiter: reference model of the ownership rules with a
// per-cycle compare, read-data queues, and hand-computed directed checks.
module tb_dat_mem_arbiter;

  localparam int LOCK_MAX = 16;
  localparam int M_IDLE = 0;
  localparam int M_CPU  = 1;
  localparam int M_HOST = 2;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdat = '0;
  logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [7:0] host_addr = '0, host_wdat = '0;
  logic       cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
  logic [7:0] cpu_rdat, host_rdat, mem_addr, mem_in, mem_out;
  logic       mem_wr_en, busy;
  logic [1:0] dbg_owner;

  dat_mem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LOCK_MAX)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdat(cpu_rdat), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdat(host_wdat),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdat(host_rdat),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
    .busy(busy), .dbg_owner(dbg_owner)
  );

  // Environment memory attached to the DUT.
  logic [7:0] tb_mem [256];
  assign mem_out = tb_mem[mem_addr];
  always @(posedge Clk) if (mem_wr_en) tb_mem[mem_addr] <= mem_in;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  int         m_owner = M_IDLE;
  int         m_run   = 0;       // consecutive host grants incl. current cycle
  int         m_last  = M_HOST;  // last granted owner
  logic       m_crv = 1'b0, m_hrv = 1'b0;
  logic [7:0] m_crdat = '0, m_hrdat = '0;
  logic [7:0] cpu_exp_q [$];
  logic [7:0] host_exp_q [$];

  function automatic int pick_owner(input int cur, input int run, input int last,
                                    input logic c, input logic h, input logic lk);
    if (cur == M_HOST && h && lk && run < LOCK_MAX) return M_HOST;
    if (c && h) begin
`ifdef DAT_MEM_ARB_RR_EN
      return (last == M_CPU) ? M_HOST : M_CPU;
`else
      return M_CPU;
`endif
    end
    if (c) return M_CPU;
    if (h) return M_HOST;
    return M_IDLE;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    int nxt;
    if (Reset) begin
      m_owner = M_IDLE; m_run = 0; m_last = M_HOST;
      m_crv = 1'b0; m_hrv = 1'b0; m_crdat = '0; m_hrdat = '0;
      cpu_exp_q.delete(); host_exp_q.delete();
    end else begin
      m_crv = 1'b0;
      m_hrv = 1'b0;
      if (m_owner == M_CPU) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdat;
        else begin
          m_crv = 1'b1; m_crdat = ref_mem[cpu_addr]; cpu_exp_q.push_back(m_crdat);
        end
      end else if (m_owner == M_HOST) begin
        if (host_we) ref_mem[host_addr] = host_wdat;
        else begin
          m_hrv = 1'b1; m_hrdat = ref_mem[host_addr]; host_exp_q.push_back(m_hrdat);
        end
      end
      nxt = pick_owner(m_owner, m_run, m_last, cpu_req, host_req, host_lock);
      m_run = (nxt == M_HOST) ? ((m_owner == M_HOST) ? m_run + 1 : 1) : 0;
      if (nxt != M_IDLE) m_last = nxt;
      m_owner = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    int e_addr, e_in, e_we;
    logic [7:0] d;
    e_addr = (m_owner == M_CPU) ? int'(cpu_addr) : (m_owner == M_HOST) ? int'(host_addr) : 0;
    e_in   = (m_owner == M_CPU) ? int'(cpu_wdat) : (m_owner == M_HOST) ? int'(host_wdat) : 0;
    e_we   = (m_owner == M_CPU) ? int'(cpu_we)   : (m_owner == M_HOST) ? int'(host_we)   : 0;
    chk("owner", int'(dbg_owner), m_owner);
    chk("cpu_gnt", int'(cpu_gnt), int'(m_owner == M_CPU));
    chk("host_gnt", int'(host_gnt), int'(m_owner == M_HOST));
    chk("mem_wr_en", int'(mem_wr_en), e_we);
    chk("mem_addr", int'(mem_addr), e_addr);
    chk("mem_in", int'(mem_in), e_in);
    chk("cpu_rvalid", int'(cpu_rvalid), int'(m_crv));
    chk("host_rvalid", int'(host_rvalid), int'(m_hrv));
    chk("cpu_rdat", int'(cpu_rdat), int'(m_crdat));
    chk("host_rdat", int'(host_rdat), int'(m_hrdat));
    chk("cpu_stall", int'(cpu_stall), int'(cpu_req && m_owner != M_CPU));
    chk("busy", int'(busy), int'(m_owner != M_IDLE || m_crv || m_hrv));
    if (cpu_rvalid) begin
      if (cpu_exp_q.size() == 0) chk("cpu_rd_queue_empty", 1, 0);
      else begin d = cpu_exp_q.pop_front(); chk("cpu_rd_queue", int'(cpu_rdat), int'(d)); end
    end
    if (host_rvalid) begin
      if (host_exp_q.size() == 0) chk("host_rd_queue_empty", 1, 0);
      else begin d = host_exp_q.pop_front(); chk("host_rd_queue", int'(host_rdat), int'(d)); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Issue one core access; returns negedges waited until gnt was seen.
  // Returns #1 after the edge closing the grant cycle (the rvalid cycle).
  task automatic cpu_op(input logic we, input logic [7:0] addr, input logic [7:0] wdat,
                        output int waits);
    cpu_we = we; cpu_addr = addr; cpu_wdat = wdat; cpu_req = 1'b1; waits = 0;
    while (cpu_req) begin
      @(negedge Clk); #1; waits++;
      if (cpu_gnt) cpu_req = 1'b0;
      else if (waits > 60) begin chk("cpu_op_timeout", waits, 0); cpu_req = 1'b0; end
    end
    tick();
  endtask

  task automatic host_op(input logic we, input logic [7:0] addr, input logic [7:0] wdat,
                         output int waits);
    host_we = we; host_addr = addr; host_wdat = wdat; host_req = 1'b1; waits = 0;
    while (host_req) begin
      @(negedge Clk); #1; waits++;
      if (host_gnt) host_req = 1'b0;
      else if (waits > 60) begin chk("host_op_timeout", waits, 0); host_req = 1'b0; end
    end
    tick();
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int w, nc, nh, run, exp_c, exp_h, wr_seen;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    tb_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;

    // Reset: outputs checked low every cycle by the compare process.
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_cpu_rdat", int'(cpu_rdat), 0);
    Reset = 1'b0;
    tick();

    // Core read of 0x10: gnt on the second negedge, data 0xA5 the cycle after.
    cpu_op(1'b0, 8'h10, 8'h00, w);
    chk("lat_cpu_read", w, 2);
    chk("cpu_rvalid_a5", int'(cpu_rvalid), 1);
    chk("cpu_rdat_a5", int'(cpu_rdat), 8'hA5);

    // Host writes 0x3C to 0x20; exactly one write-enable cycle at 0x20.
    host_we = 1'b1; host_addr = 8'h20; host_wdat = 8'h3C; host_req = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); #1;
      if (mem_wr_en && mem_addr == 8'h20 && mem_in == 8'h3C) wr_seen++;
      if (host_gnt) host_req = 1'b0;
    end
    chk("host_write_cycles", wr_seen, 1);
    chk("host_write_no_rvalid", int'(host_rvalid), 0);
    cpu_op(1'b0, 8'h20, 8'h00, w);
    chk("cpu_rdat_3c", int'(cpu_rdat), 8'h3C);

    // Core write then host read of the same location.
    cpu_op(1'b1, 8'h50, 8'h55, w);
    host_op(1'b0, 8'h50, 8'h00, w);
    chk("host_rdat_55", int'(host_rdat), 8'h55);
    tick();

    // Both request continuously without lock.
    cpu_we = 1'b0; cpu_addr = 8'h10; host_we = 1'b0; host_addr = 8'h11;
    cpu_req = 1'b1; host_req = 1'b1;
    tick();
    nc = 0; nh = 0;
    repeat (12) begin
      @(negedge Clk);
      if (cpu_gnt) nc++;
      if (host_gnt) nh++;
    end
    #1; cpu_req = 1'b0; host_req = 1'b0;
`ifdef DAT_MEM_ARB_RR_EN
    exp_c = 6; exp_h = 6;
`else
    exp_c = 12; exp_h = 0;
`endif
    chk("contend_cpu_grants", nc, exp_c);
    chk("contend_host_grants", nh, exp_h);
    repeat (3) tick();

    // Locked host run: 16 host grants, then the waiting core gets one.
    host_we = 1'b0; host_addr = 8'h30; host_lock = 1'b1; host_req = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    run = 0; nc = 0;
    for (int i = 0; i < 40 && nc == 0; i++) begin
      @(negedge Clk);
      if (host_gnt) begin
        run++;
        chk("lock_stall", int'(cpu_stall), 1);
      end
      if (cpu_gnt) nc++;
      #1;
      if (cpu_gnt) begin cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0; end
    end
    chk("lock_host_run", run, LOCK_MAX);
    chk("lock_cpu_after", nc, 1);
    repeat (3) tick();

    // Reset while a host read is granted; core wins first afterwards.
    host_we = 1'b0; host_addr = 8'h40; host_req = 1'b1;
    tick();
    chk("pre_reset_host_gnt", int'(host_gnt), 1);
    #2; Reset = 1'b1; #1;
    chk("rst_host_gnt", int'(host_gnt), 0);
    chk("rst_host_rvalid", int'(host_rvalid), 0);
    chk("rst_mem_wr_en", int'(mem_wr_en), 0);
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("post_rst_cpu_first", int'(cpu_gnt), 1);
    chk("post_rst_host_wait", int'(host_gnt), 0);
    cpu_req = 1'b0;
    for (int i = 0; i < 10 && host_req; i++) begin
      @(negedge Clk); #1;
      if (host_gnt) host_req = 1'b0;
    end
    chk("post_rst_host_served", int'(host_req), 0);
    repeat (2) tick();

    // Idle: nothing moves.
    repeat (6) begin
      @(negedge Clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_mem_addr", int'(mem_addr), 0);
      chk("idle_mem_wr_en", int'(mem_wr_en), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dat_mem_arbiter.md
# dat_mem_arbiter

Shares the single-port data memory between the core's load/store path and a host port (program/data loader, result readback) so the memory can be preloaded and inspected without halting the design. Grants at most one access per cycle, drives the memory's write enable, address and write-data inputs, and returns registered read data to the winning requester. Sits between the core's memory controls, the host interface and the data memory; the core stalls on `cpu_stall`.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `LOCK_MAX`, 16, max consecutive host grants under `host_lock` before a forced release to a waiting core request

- `Clk` in 1: sole clock, rising edge
- `Reset` in 1: asynchronous, active-high
- `cpu_req`, `cpu_we` in 1: core access request / write
- `cpu_addr` in AW, `cpu_wdat` in DW: core address / write data
- `cpu_gnt` out 1: core access performed this cycle
- `cpu_rvalid` out 1, `cpu_rdat` out DW: core read data valid / data
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`, combinational
- `host_req`, `host_we`, `host_lock` in 1: host request / write / keep-ownership
- `host_addr` in AW, `host_wdat` in DW
- `host_gnt`, `host_rvalid` out 1, `host_rdat` out DW
- `mem_wr_en` out 1, `mem_addr` out AW, `mem_in` out DW: to data memory
- `mem_out` in DW: memory read data, combinational w.r.t. `mem_addr`
- `busy` out 1: any grant or rvalid high

## Operation
- Owner state, registered: IDLE, CPU, HOST. Each grant state = one memory access cycle.
- Each rising edge: next owner = arbitration over `cpu_req`, `host_req`. Neither -> IDLE.
- A requester holds req/we/addr/wdat stable until it sees its gnt. Req still high in a cycle where its gnt is high = new transaction.
- Default arbitration: core wins when both request.
- Host lock: owner HOST, `host_req & host_lock` high -> HOST retained even if `cpu_req`, until lock counter reaches `LOCK_MAX`; then next cycle goes to CPU if `cpu_req`, else HOST continues. Counter clears on any non-HOST cycle.
- Granted cycle: `mem_addr`/`mem_in` = owner's addr/wdat; `mem_wr_en` = owner's we. IDLE: all mem outputs 0.
- Read (we=0) grant: `mem_out` captured at end of grant cycle into owner's rdat register; rvalid high one cycle. Writes raise no rvalid.
- rdat registers hold last value between reads.

## Timing
- Reset: owner IDLE, all gnt/rvalid 0, rdat 0, mem outputs 0, lock counter 0, round-robin pointer = "host last" (core first).
- Latency: req high before edge N -> gnt in cycle N -> rvalid + rdat in cycle N+1.
- Throughput: one access per cycle; continuous core requests get gnt every cycle.
- Simultaneous requests from IDLE: per arbitration rule; loser's stall held until granted.
- Reset mid-access: grant dropped immediately (async); a write in flight in that cycle is not guaranteed.
- `host_lock` with `host_req` low: ignored; HOST released.

## Configuration
- `DAT_MEM_ARB_RR_EN` defined: when both request and no lock active, winner alternates (pointer = last-granted owner, updated on every grant). Undefined: fixed core priority; host can starve except via `host_lock`.

## Structure
- Package `dat_mem_arb_pkg`: owner enum typedef (`ARB_IDLE`, `ARB_CPU`, `ARB_HOST`), default `AW`/`DW`/`LOCK_MAX` constants.
- Sub-module `arb_lock_ctr`: saturating lock counter, clear/increment inputs, `at_max` output.

## Test plan
- Reset then `cpu_req`, we=0, addr 0x10, mem[0x10]=0xA5 -> `cpu_gnt` next cycle, `cpu_rvalid`=1 and `cpu_rdat`=0xA5 cycle after; all outputs 0 during reset.
- Host write 0x3C to 0x20, then core read 0x20 -> `mem_wr_en`=1 one cycle with addr 0x20, core later reads 0x3C.
- Both request every cycle, no lock: without macro core gets all grants, `host_gnt` stays 0; with `DAT_MEM_ARB_RR_EN` grants alternate CPU, HOST, CPU...
- Host holds grant with `host_lock`=1, core requesting -> exactly 16 consecutive host grants, then one core grant; `cpu_stall` high throughout wait.
- Reset asserted while host read granted -> `host_gnt`, `host_rvalid`, `mem_wr_en` drop immediately; after release core request served first.
- No requests -> `busy`=0, `mem_addr`=0, `mem_wr_en`=0 every cycle.
